pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch PC register and sequences it.
- Advances by 4 on each accepted fetch and holds on stall or memory not-ready.
- Redirects to the resolved target when the EX-stage next-PC logic reports a taken branch or jump, flushing the younger IF/ID and ID/EX stages.
- Provides boot, one-cycle redirect bubble and halt sequencing, plus a saturating redirect counter for performance monitoring.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  hazard-unit stall; hold PC.
imem_ready_i  input  1  instruction memory accepts the request this cycle.
ex_valid_i  input  1  EX-stage instruction is valid (not a bubble).
take_branch_i  input  1  taken branch/jump resolved in EX.
branch_target_i  input  32  resolved target from EX.
halt_i  input  1  halt request (ebreak/ecall halt) from the pipeline.
pc_o  output  32  current fetch PC.
pc_valid_o  output  1  fetch request valid.
flush_if_id_o  output  1  flush IF/ID register this cycle.
flush_id_ex_o  output  1  flush ID/EX register this cycle.
misalign_o  output  1  one-cycle registered pulse: redirect target had bit 1 set.
redirect_cnt_o  output  32  count of accepted redirects, saturating.
state_o  output  2  FSM state: 0 BOOT, 1 RUN, 2 REDIRECT, 3 HALTED.

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - pc_o=RESET_VECTOR, state BOOT, pc_valid_o=0.
  - flush_if_id_o=0, flush_id_ex_o=0, misalign_o=0, redirect_cnt_o=0.
- Reset mid-operation returns everything to these values immediately.
- pc_valid_o=1 only in RUN.
- Flush outputs are combinational and nonzero only in RUN on an accepted redirect. All other outputs are registered.
- Accepted redirect (redir) = state RUN && ex_valid_i && take_branch_i && !halt_i.
- Accepted fetch (fire) = state RUN && imem_ready_i && !stall_i && !redir && !halt_i.
- BOOT: unconditionally to RUN next cycle; pc_o holds RESET_VECTOR; all inputs ignored.
- RUN, priority order, highest first:
  1. halt_i: go to HALTED; pc_o holds; no flush; counter unchanged.
  2. redir:
     - flush_if_id_o=flush_id_ex_o=1 in the same cycle.
     - Next pc_o={branch_target_i[31:2],2'b00}.
     - misalign_o=branch_target_i[1] on the next cycle.
     - redirect_cnt_o+1, saturating at 32'hFFFF_FFFF.
     - Go to REDIRECT.
     - Redirect overrides stall_i and imem_ready_i.
  3. fire: pc_o<=pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  4. Otherwise (stall or not ready): hold pc_o.
- REDIRECT:
  - Exactly one bubble cycle: pc_valid_o=0, pc_o holds the target, no flushes.
  - Returns to RUN next cycle regardless of stall_i, imem_ready_i, take_branch_i or halt_i. halt_i seen here is ignored; the pipeline re-asserts it.
- HALTED:
  - Absorbing: pc_valid_o=0, pc_o frozen, flushes 0, counter frozen.
  - Only rst_n exits.
- take_branch_i with ex_valid_i=0 is ignored in all states.
- misalign_o is 0 in every cycle not immediately following a redir.
- Latency: taken branch at cycle N, target on pc_o with pc_valid_o=1 at cycle N+2.

Test Plan:
- Reset then free-run: RESET_VECTOR=32'h0000_1000, imem_ready_i=1. Required: cycle 0 BOOT pc_valid_o=0; then pc_o 1000, 1004, 1008 with pc_valid_o=1.
- Stall / not-ready:
  - In RUN at pc 0x1008, stall_i=1 for 3 cycles: pc_o holds 0x1008.
  - With imem_ready_i=0 for 2 cycles: pc_o holds 0x1008.
  - Then resumes at 0x100C.
- Redirect beats stall:
  - Inputs: ex_valid_i=take_branch_i=1, target 0x2000, stall_i=1.
  - Required: both flushes=1 that cycle; next cycle REDIRECT pc_o=0x2000 pc_valid_o=0; following cycle RUN pc_valid_o=1; redirect_cnt_o=1.
- Misaligned target and wrap:
  - Target 0x3002: pc_o=0x3000 and misalign_o pulses for one cycle.
  - Separately, pc 0xFFFF_FFFC with fire: next pc_o=0.
- Halt priority and absorption:
  - halt_i and take_branch_i asserted together in RUN: no flush, counter unchanged, state HALTED.
  - Subsequent redirect and ready inputs leave pc_o frozen until rst_n pulses low asynchronously mid-cycle, after which all outputs show their reset values.
- Gating and saturation:
  - take_branch_i=1 with ex_valid_i=0: no redirect.
  - redirect_cnt_o preloaded via 2^32-1 redirects (or forced) stays at 32'hFFFF_FFFF on a further redirect.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and the rest of the pipeline.
// The master modport is the sequencer; the slave modport is the pipeline/bench side.
interface pc_sequencer_if;
  logic        stall_i;
  logic        imem_ready_i;
  logic        ex_valid_i;
  logic        take_branch_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        misalign_o;
  logic [31:0] redirect_cnt_o;
  logic [1:0]  state_o;

  modport master (
    input  stall_i, imem_ready_i, ex_valid_i, take_branch_i, branch_target_i, halt_i,
    output pc_o, pc_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o,
           redirect_cnt_o, state_o
  );

  modport slave (
    output stall_i, imem_ready_i, ex_valid_i, take_branch_i, branch_target_i, halt_i,
    input  pc_o, pc_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o,
           redirect_cnt_o, state_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register with boot, redirect-bubble and halt sequencing, plus a
// saturating count of accepted redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_sequencer: RESET_VECTOR must be 4-byte aligned");
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic        misalign_q, misalign_d;

  logic        in_run;
  logic        redir;
  logic        fire;
  logic        tgt_bit0_unused;

  // Bit 0 of the target is dropped with bit 1; only bit 1 is reported as misalignment.
  assign tgt_bit0_unused = bus.branch_target_i[0];

  always_comb begin
    in_run = (state_q == ST_RUN);
    redir  = in_run && bus.ex_valid_i && bus.take_branch_i && !bus.halt_i;
    fire   = in_run && bus.imem_ready_i && !bus.stall_i && !redir && !bus.halt_i;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redirect_cnt_d = redirect_cnt_q;
    misalign_d     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt_i) begin
          state_d = ST_HALTED;
        end else if (redir) begin
          pc_d           = {bus.branch_target_i[31:2], 2'b00};
          misalign_d     = bus.branch_target_i[1];
          redirect_cnt_d = (redirect_cnt_q == '1) ? redirect_cnt_q : redirect_cnt_q + 32'd1;
          state_d        = ST_REDIRECT;
        end else if (fire) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_RUN;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      redirect_cnt_q <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redirect_cnt_q <= redirect_cnt_d;
      misalign_q     <= misalign_d;
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.pc_valid_o     = in_run;
  assign bus.flush_if_id_o  = redir;
  assign bus.flush_id_ex_o  = redir;
  assign bus.misalign_o     = misalign_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle-level reference model pushes the
// expected outputs for each driven cycle; a negedge monitor pops and compares.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();
  pc_sequencer #(.RESET_VECTOR(RV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [31:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: mode is 0 boot, 1 run, 2 redirect bubble, 3 halted.
  logic [31:0] m_pc;
  int          m_st;
  logic        m_mis;
  logic [31:0] m_cnt;
  bit          force_pending = 1'b0;

  task automatic model_reset();
    m_pc = RV; m_st = 0; m_mis = 1'b0; m_cnt = 32'd0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    logic [1:0] s;
    s       = m_st[1:0];
    e.pc    = m_pc;
    e.valid = (m_st == 1);
    e.flush = (m_st == 1) && bus.ex_valid_i && bus.take_branch_i && !bus.halt_i;
    e.mis   = m_mis;
    e.cnt   = m_cnt;
    e.st    = s;
    return e;
  endfunction

  task automatic model_advance(input logic redirect_taken);
    logic [31:0] t;
    t     = bus.branch_target_i;
    m_mis = 1'b0;
    case (m_st)
      0: m_st = 1;
      1: begin
        if (bus.halt_i) m_st = 3;
        else if (redirect_taken) begin
          m_pc  = {t[31:2], 2'b00};
          m_mis = t[1];
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
          m_st  = 2;
        end else if (bus.imem_ready_i && !bus.stall_i) m_pc = m_pc + 32'd4;
      end
      2: m_st = 1;
      default: ;
    endcase
  endtask

  task automatic step(input logic stall, input logic ready, input logic exv,
                      input logic tk, input logic [31:0] tgt, input logic halt);
    exp_t e;
    @(posedge clk);
    #1;
    if (force_pending) begin
      force dut.redirect_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.redirect_cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      force_pending = 1'b0;
    end
    rst_n               = 1'b1;
    bus.stall_i         = stall;
    bus.imem_ready_i    = ready;
    bus.ex_valid_i      = exv;
    bus.take_branch_i   = tk;
    bus.branch_target_i = tgt;
    bus.halt_i          = halt;
    e = model_outputs();
    q.push_back(e);
    model_advance(e.flush);
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    q.push_back(model_outputs());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", bus.pc_o, e.pc);
      chk("pc_valid", {31'd0, bus.pc_valid_o}, {31'd0, e.valid});
      chk("flush_if_id", {31'd0, bus.flush_if_id_o}, {31'd0, e.flush});
      chk("flush_id_ex", {31'd0, bus.flush_id_ex_o}, {31'd0, e.flush});
      chk("misalign", {31'd0, bus.misalign_o}, {31'd0, e.mis});
      chk("redirect_cnt", bus.redirect_cnt_o, e.cnt);
      chk("state", {30'd0, bus.state_o}, {30'd0, e.st});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int halted_cycles;
    bus.stall_i = 1'b0; bus.imem_ready_i = 1'b0; bus.ex_valid_i = 1'b0;
    bus.take_branch_i = 1'b0; bus.branch_target_i = 32'd0; bus.halt_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    q.push_back(model_outputs());

    // Boot and free-run: 1000, 1004, then stall/not-ready at 1008.
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    repeat (3) step(1, 1, 0, 0, 32'h0, 0);
    repeat (2) step(0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // Redirect wins over stall, then bubble, then run.
    step(1, 1, 1, 1, 32'h0000_2000, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // Misaligned target, one-cycle misalign pulse.
    step(0, 1, 1, 1, 32'h0000_3002, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // PC wrap from FFFF_FFFC.
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // take_branch without ex_valid is ignored.
    step(0, 1, 0, 1, 32'h0000_5000, 0);
    step(0, 1, 0, 1, 32'h0000_5000, 0);

    // Counter saturation from a preloaded near-max value.
    force_pending = 1'b1;
    step(0, 1, 1, 1, 32'h0000_0040, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 1, 1, 32'h0000_0080, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // Halt beats redirect; halted state absorbs everything until reset.
    step(0, 1, 1, 1, 32'h0000_9000, 1);
    repeat (4) step(0, 1, 1, 1, 32'h0000_A000, 0);
    reset_mid();
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);

    // Randomized traffic.
    halted_cycles = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      if (m_st == 3) halted_cycles++;
      else halted_cycles = 0;
      if (halted_cycles > 3) begin
        reset_mid();
        halted_cycles = 0;
      end else begin
        step(($urandom_range(3) == 0), ($urandom_range(3) != 0), ($urandom_range(1) == 1),
             ($urandom_range(2) == 0), $urandom, ($urandom_range(63) == 0));
      end
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
